// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 inverse key schedule:
//   NUM_ROUNDS - round count for AES-128 (10); also the first round emitted
//   state_t    - two-state sequencer encoding (IDLE, EMIT)
//   rcon()     - round constant used when stepping from round r to round r-1
// No ports (package).
// ----------------------------------------------------------------------------
package aes_pkg;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Round constant that was mixed in when round r was derived from round r-1
  // in the forward expansion; undoing that step needs the same value.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd10:   return 8'h36;
      4'd9:    return 8'h1b;
      4'd8:    return 8'h80;
      4'd7:    return 8'h40;
      4'd6:    return 8'h20;
      4'd5:    return 8'h10;
      4'd4:    return 8'h08;
      4'd3:    return 8'h04;
      4'd2:    return 8'h02;
      4'd1:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/g_function.sv
// ----------------------------------------------------------------------------
// g_function
// Purely combinational SubWord(RotWord(word)) for the AES key schedule.
// The S-box is computed arithmetically (GF(2^8) inverse followed by the AES
// affine transform) rather than stored as a table.
// Ports:
//   word   in  [31:0]  input word, byte 0 in [31:24]
//   result out [31:0]  SubWord(RotWord(word))
// ----------------------------------------------------------------------------
module g_function (
  input  logic [31:0] word,
  output logic [31:0] result
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, which
  // is exactly what the S-box needs before the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // RotWord moves byte 0 to the end before substitution.
  assign result = {sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0]), sbox(word[31:24])};

endmodule

// File: rtl/aes_128_inv_key_schedule.sv
// ----------------------------------------------------------------------------
// aes_128_inv_key_schedule
// Walks the AES-128 key schedule backwards: accepts the round-10 key and
// emits round keys 10, 9, ..., 0 over a valid/ready stream, one per cycle
// when the consumer is always ready.
// Ports:
//   clk        in        clock, rising edge
//   rst_n      in        asynchronous active-low reset
//   in_valid   in        in_key is valid
//   in_ready   out       key accepted this cycle (IDLE and out of reset)
//   in_key     in [127:0] round-10 key {w40,w41,w42,w43}, w40 in [127:96]
//   out_valid  out       out_key/out_round valid
//   out_ready  in        consumer takes the current output
//   out_key    out [127:0] round key for out_round, same word order
//   out_round  out [3:0]  round index, 10 down to 0
//   out_last   out       marks round 0
// Build option AES_INV_KS_ZEROIZE_EN: clears the key register once round 0
// has been taken and masks out_key to 0 whenever out_valid is low.
// ----------------------------------------------------------------------------
module aes_128_inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last
);

  state_t       state;
  logic [127:0] key;
  logic [3:0]   round;

  logic [31:0]  wa, wb, wc, wd;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  g_out;
  logic [127:0] prev_key;

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready = (state == IDLE) && rst_n;

  // Predecessor round key: each forward word was the XOR of its left
  // neighbour and the word four positions back, so XORing adjacent words
  // recovers the older ones; the first word needs g() of the recovered p3.
  assign {wa, wb, wc, wd} = key;
  assign p3 = wd ^ wc;
  assign p2 = wc ^ wb;
  assign p1 = wb ^ wa;

  g_function u_g_function (
    .word   (p3),
    .result (g_out)
  );

  assign p0       = wa ^ g_out ^ {rcon(round), 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= '0;
      round     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            key       <= in_key;
            round     <= NUM_ROUNDS;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          // Key, round and last only move on a completed handshake, which
          // keeps the output stable across consumer stalls.
          if (out_ready) begin
            if (round == 4'd0) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
`ifdef AES_INV_KS_ZEROIZE_EN
              key       <= '0;
`endif
            end else begin
              key      <= prev_key;
              round    <= round - 4'd1;
              out_last <= (round == 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_round = round;

`ifdef AES_INV_KS_ZEROIZE_EN
  assign out_key = out_valid ? key : '0;
`else
  assign out_key = key;
`endif

endmodule

// File: tb/tb_aes_128_inv_key_schedule.sv
module tb_aes_128_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   round;
    logic         last;
  } exp_t;

  exp_t sb[$];

  localparam logic [127:0] KEY_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R9_A  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] R1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R0_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  always #5 clk = ~clk;

  aes_128_inv_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_key   (out_key),
    .out_round (out_round),
    .out_last  (out_last)
  );

  function automatic logic [7:0] rcon_of(input int r);
    case (r)
      10: return 8'h36;  9: return 8'h1b;  8: return 8'h80;  7: return 8'h40;
      6:  return 8'h20;  5: return 8'h10;  4: return 8'h08;  3: return 8'h04;
      2:  return 8'h02;  1: return 8'h01;  default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [127:0] prev_key(input logic [127:0] k, input int r);
    logic [31:0] a, b, c, d, q0, q1, q2, q3;
    {a, b, c, d} = k;
    q3 = d ^ c;
    q2 = c ^ b;
    q1 = b ^ a;
    q0 = a ^ sub_rot(q3) ^ {rcon_of(r), 24'h000000};
    return {q0, q1, q2, q3};
  endfunction

  task automatic push_expected(input logic [127:0] k0);
    logic [127:0] k;
    exp_t e;
    k = k0;
    for (int r = 10; r >= 0; r--) begin
      e.key   = k;
      e.round = 4'(r);
      e.last  = (r == 0);
      sb.push_back(e);
      k = prev_key(k, r);
    end
  endtask

  // Presents a key on the input until it is accepted; returns at posedge+1.
  task automatic send_key(input logic [127:0] k);
    in_valid = 1'b1;
    in_key   = k;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_key = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    checks++; if (out_key !== 128'h0) begin errors++; $display("FAIL reset_out_key: got %h need 0", out_key); end
    checks++; if (out_round !== 4'd0) begin errors++; $display("FAIL reset_out_round: got %0d need 0", out_round); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b need 0", out_last); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b need 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_known_vector;
    exp_t e;
    sb.delete();
    push_expected(KEY_A);
    out_ready = 1'b1;
    send_key(KEY_A);
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL kv_valid cycle %0d: out_valid=%b need 1", cyc, out_valid);
      end else begin
        e = sb.pop_front();
        if (out_key !== e.key || out_round !== e.round || out_last !== e.last) begin
          errors++;
          $display("FAIL kv_out cycle %0d: got %h r%0d l%b need %h r%0d l%b", cyc, out_key, out_round, out_last, e.key, e.round, e.last);
        end
        if (e.round == 4'd9) begin
          checks++; if (out_key !== R9_A) begin errors++; $display("FAIL kv_round9: got %h need %h", out_key, R9_A); end
        end
        if (e.round == 4'd1) begin
          checks++; if (out_key !== R1_A) begin errors++; $display("FAIL kv_round1: got %h need %h", out_key, R1_A); end
        end
        if (e.round == 4'd0) begin
          checks++; if (out_key !== R0_A || out_last !== 1'b1) begin errors++; $display("FAIL kv_round0: got %h l%b need %h l1", out_key, out_last, R0_A); end
        end
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL kv_return_idle: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready); end
`ifdef AES_INV_KS_ZEROIZE_EN
    checks++; if (out_key !== 128'h0 || dut.key !== 128'h0) begin errors++; $display("FAIL idle_key: got %h reg %h need 0", out_key, dut.key); end
`else
    checks++; if (out_key !== R0_A || dut.key !== R0_A) begin errors++; $display("FAIL idle_key: got %h reg %h need %h", out_key, dut.key, R0_A); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_zero_key;
    exp_t e;
    sb.delete();
    push_expected(KEY_Z);
    out_ready = 1'b1;
    send_key(KEY_Z);
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL zk_valid cycle %0d: out_valid=%b need 1", cyc, out_valid);
      end else begin
        e = sb.pop_front();
        if (out_key !== e.key || out_round !== e.round || out_last !== e.last) begin
          errors++;
          $display("FAIL zk_out cycle %0d: got %h r%0d l%b need %h r%0d l%b", cyc, out_key, out_round, out_last, e.key, e.round, e.last);
        end
        if (e.round == 4'd0) begin
          checks++; if (out_key !== 128'h0) begin errors++; $display("FAIL zk_round0: got %h need 0", out_key); end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int pops;
    int stalls;
    exp_t e;
    sb.delete();
    push_expected(KEY_A);
    out_ready = 1'b0;
    send_key(KEY_A);
    pops = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 300 && pops < 11; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL bp_valid cycle %0d: out_valid=%b need 1", cyc, out_valid);
      end else begin
        // Stalled or not, the presented value must be the head of the queue.
        e = sb[0];
        if (out_key !== e.key || out_round !== e.round || out_last !== e.last) begin
          errors++;
          $display("FAIL bp_out cycle %0d ready %b: got %h r%0d l%b need %h r%0d l%b", cyc, out_ready, out_key, out_round, out_last, e.key, e.round, e.last);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          pops++;
        end else begin
          stalls++;
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (pops != 11) begin errors++; $display("FAIL bp_count: got %0d outputs need 11 (stalls %0d)", pops, stalls); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: out_valid=%b need 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit seen;
    sb.delete();
    out_ready = 1'b1;
    send_key(KEY_A);
    // Rounds 10..6 are taken on the next five edges; round 5 is then on show.
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_round !== 4'd5) begin errors++; $display("FAIL rm_at_round5: valid %b round %0d need 1 5", out_valid, out_round); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_round !== 4'd0 || out_key !== 128'h0) begin
      errors++; $display("FAIL rm_reset_now: valid %b ready %b round %0d key %h need 0 0 0 0", out_valid, in_ready, out_round, out_key);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_release_ready: got %b need 1", in_ready); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rm_no_output: out_valid seen 1 need 0"); end
    @(posedge clk); #1;
    push_expected(KEY_Z);
    send_key(KEY_Z);
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL rm_valid cycle %0d: out_valid=%b need 1", cyc, out_valid);
      end else begin
        e = sb.pop_front();
        if (out_key !== e.key || out_round !== e.round || out_last !== e.last) begin
          errors++;
          $display("FAIL rm_out cycle %0d: got %h r%0d l%b need %h r%0d l%b", cyc, out_key, out_round, out_last, e.key, e.round, e.last);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int accepts;
    int pops;
    bit overlap;
    exp_t e;
    sb.delete();
    push_expected(KEY_A);
    push_expected(KEY_Z);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_key    = KEY_A;
    accepts = 0;
    pops = 0;
    overlap = 1'b0;
    for (int cyc = 0; cyc < 60 && pops < 22; cyc++) begin
      @(negedge clk);
      if (in_ready && out_valid) overlap = 1'b1;
      if (in_valid && in_ready) accepts++;
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra cycle %0d: unexpected output %h r%0d", cyc, out_key, out_round);
        end else begin
          e = sb.pop_front();
          pops++;
          if (out_key !== e.key || out_round !== e.round || out_last !== e.last) begin
            errors++;
            $display("FAIL b2b_out cycle %0d: got %h r%0d l%b need %h r%0d l%b", cyc, out_key, out_round, out_last, e.key, e.round, e.last);
          end
        end
      end
      @(posedge clk); #1;
      // Swap in the second key right after the first capture; it must wait.
      if (accepts == 1) in_key = KEY_Z;
      if (accepts == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (pops != 22 || accepts != 2) begin errors++; $display("FAIL b2b_count: outputs %0d accepts %0d need 22 2", pops, accepts); end
    checks++; if (overlap) begin errors++; $display("FAIL b2b_overlap: in_ready and out_valid both 1 need exclusive"); end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_vector();
    test_zero_key();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_128_inv_key_schedule.md
AES_128_INV_KEY_SCHEDULE -- requirements
Module: aes_128_inv_key_schedule

Interface
- REQ-001 The block SHALL have no parameters; AES-128 with 10 rounds is fixed.
- REQ-002 clk  input  1  single clock, rising edge.
- REQ-003 rst_n  input  1  reset, asynchronous, active-low.
- REQ-004 in_valid  input  1  in_key is valid.
- REQ-005 in_ready  output  1  block accepts in_key this cycle.
- REQ-006 in_key  input  128  final round key (round 10), {w40,w41,w42,w43}, w40 in [127:96].
- REQ-007 out_valid  output  1  out_key/out_round valid.
- REQ-008 out_ready  input  1  consumer accepts the current output.
- REQ-009 out_key  output  128  round key for out_round, same word order as in_key.
- REQ-010 out_round  output  4  round index of out_key, 10 down to 0.
- REQ-011 out_last  output  1  high with out_valid when out_round==0.

Function
- REQ-012 The FSM SHALL have exactly two states: IDLE and EMIT.
- REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, register in_key, set round=10 and go to EMIT.
- REQ-014 EMIT: in_ready=0, out_valid=1, out_key=key register, out_round=round register.
- REQ-015 Latency: round 10 is presented on the cycle after input acceptance and equals in_key bit-exact.
- REQ-016 The output handshake SHALL complete on out_valid&&out_ready.
- REQ-017 While out_valid&&!out_ready, out_key, out_round and out_last SHALL hold stable.
- REQ-018 On a handshake at round r>0, the next cycle SHALL present round r-1.
- REQ-019 The step from round key {a,b,c,d} to its predecessor {p0,p1,p2,p3} SHALL compute p3=d^c, p2=c^b, p1=b^a and p0=a^SubWord(RotWord(p3))^{rcon_r,24'b0}.
- REQ-020 rcon_r for r=10..1 SHALL be 36,1b,80,40,20,10,08,04,02,01 (hex).
- REQ-021 On a handshake at round 0, the FSM SHALL return to IDLE, with in_ready=1 the next cycle.
- REQ-022 Input and output handshakes SHALL NOT be accepted in the same cycle.
- REQ-023 The step SHALL be one combinational stage between registers; throughput is one round key per cycle when out_ready=1, so a full sequence takes 11 cycles.

Reset
- REQ-024 Assertion of rst_n=0 SHALL immediately force IDLE, with key register=0, round=0, out_valid=0, out_last=0, out_key=0 and out_round=0.
- REQ-025 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
- REQ-026 Reset mid-sequence SHALL abort it with no further output; the next accepted key restarts at round 10.

Configuration
- REQ-027 With macro AES_INV_KS_ZEROIZE_EN defined, the key register SHALL be cleared to 0 on the cycle the round-0 handshake completes, and out_key SHALL read 0 whenever out_valid=0.
- REQ-028 Without AES_INV_KS_ZEROIZE_EN, the key register SHALL retain the round-0 key in IDLE.
- REQ-029 Without AES_INV_KS_ZEROIZE_EN, out_key in IDLE SHALL be the register contents (don't-care to consumers).

Structure
- REQ-030 The rcon table, round-count constant (10) and FSM state enum SHALL reside in a shared package, aes_pkg.
- REQ-031 SubWord(RotWord()) SHALL be an instance of the existing g_function sub-module; no other sub-module.

Verification
- REQ-032 Input d014f9a8c9ee2589e13f0cc8b6630ca6 with out_ready=1 -> outputs on 11 consecutive cycles; round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c with out_last=1.
- REQ-033 Input b4ef5bcb3e92e21123e951cf6f8f188e -> round 0 = 0 after 11 outputs.
- REQ-034 Random out_ready backpressure (about 50% duty) on REQ-032's vector -> identical 11-key sequence; output stable across every stall.
- REQ-035 rst_n pulsed low at round 5 -> out_valid drops immediately; in_ready=1 after release; a new key produces a full sequence from round 10.
- REQ-036 in_valid held high during EMIT -> no second capture; the second key is accepted only after round 0 completes.
- REQ-037 Build both with and without AES_INV_KS_ZEROIZE_EN -> key register is 0 after completion only when the macro is defined.
